// File: rtl/prime_candidate_gen.sv
// prime_candidate_gen: gathers a random odd, MSB-set candidate, drives miller_rabin, and walks a
// +2 search (regathering after MAX_STEPS tests) until one verified prime is found per go request.
module prime_candidate_gen #(
    parameter int WORDSIZE  = 32,
    parameter int MAX_STEPS = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [15:0]         rand_in,
    output logic [WORDSIZE-1:0] mr_number,
    output logic                mr_start,
    input  logic                mr_finish,
    input  logic                mr_prime,
    output logic [WORDSIZE-1:0] prime_out,
    output logic                prime_valid,
    output logic                busy,
    output logic [15:0]         attempts
);

    localparam int NWORDS = WORDSIZE / 16;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NWORDS - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATHER,
        S_START,
        S_ARM,
        S_WAIT,
        S_STEP,
        S_DONE
    } state_e;

    state_e              state_q,    state_d;
    logic [WORDSIZE-1:0] number_q,   number_d;
    logic [WORDSIZE-1:0] prime_q,    prime_d;
    logic [15:0]         attempts_q, attempts_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [STEP_W-1:0]   step_q,     step_d;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge values computed by the combinational block below.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            number_q   <= '0;
            prime_q    <= '0;
            attempts_q <= '0;
            idx_q      <= '0;
            step_q     <= '0;
        end else begin
            state_q    <= state_d;
            number_q   <= number_d;
            prime_q    <= prime_d;
            attempts_q <= attempts_d;
            idx_q      <= idx_d;
            step_q     <= step_d;
        end
    end

    // NOTE: every next-state variable is defaulted to its current value first, so no branch
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        number_d   = number_q;
        prime_d    = prime_q;
        attempts_d = attempts_q;
        idx_d      = idx_q;
        step_d     = step_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    attempts_d = '0;
                    idx_d      = '0;
                    step_d     = '0;
                    state_d    = S_GATHER;
                end
            end

            S_GATHER: begin
                for (int w = 0; w < NWORDS; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        number_d[w*16 +: 16] = rand_in;
                    end
                end
                // Force odd and full-width on the final word so the candidate is never trivially small.
                if (idx_q == LAST_IDX) begin
                    number_d[0]          = 1'b1;
                    number_d[WORDSIZE-1] = 1'b1;
                    idx_d                = '0;
                    state_d              = S_START;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_START: state_d = S_ARM;

            // A finish left high by the previous test is deliberately not looked at here.
            S_ARM: state_d = S_WAIT;

            S_WAIT: begin
                if (mr_finish) begin
                    if (attempts_q != 16'hFFFF) begin
                        attempts_d = attempts_q + 16'd1;
                    end
                    if (mr_prime) begin
                        prime_d = number_q;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end

            S_STEP: begin
                // The all-ones check also guards the +2 against wrapping to a small value.
                if (step_q == LAST_STEP || number_q == '1) begin
                    step_d  = '0;
                    idx_d   = '0;
                    state_d = S_GATHER;
                end else begin
                    number_d = number_q + WORDSIZE'(2);
                    step_d   = step_q + 1'b1;
                    state_d  = S_START;
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    assign mr_number   = number_q;
    assign mr_start    = (state_q == S_START);
    assign prime_out   = prime_q;
    assign prime_valid = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign attempts    = attempts_q;

endmodule
